// File: rtl/rf_pkg.sv
// Shared types and constants for the multi-port register file with pending
// scoreboard and bulk-clear engine.
package rf_pkg;

  typedef enum logic [0:0] {
    RF_IDLE  = 1'b0,
    RF_CLEAR = 1'b1
  } rf_state_e;

  localparam int unsigned RF_XLEN_DEF = 32;
  localparam int unsigned RF_NREG_DEF = 32;

  // At least one address bit, even for the degenerate two-register file.
  function automatic int unsigned rf_aw(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rf_clear_fsm.sv
// Sequential bulk-clear engine: walks idx from 1 to NREG-1, one register per
// enabled cycle, and pulses done_o once the last register has been cleared.
module rf_clear_fsm
  import rf_pkg::*;
#(
  parameter int unsigned NREG = RF_NREG_DEF,
  parameter int unsigned AW   = rf_aw(NREG)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          enb_i,
  input  logic          clr_req_i,
  output logic          busy_o,
  output logic          done_o,
  output logic          clr_we_o,
  output logic [AW-1:0] clr_idx_o,
  output rf_state_e     state_o
);

  localparam logic [AW-1:0] LastIdx = AW'(NREG - 1);

  rf_state_e     state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic          done_q, done_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= RF_IDLE;
      idx_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
    end
  end

  // Register 0 is hardwired, so the walk starts at 1; enb_i=0 freezes it.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    case (state_q)
      RF_IDLE: begin
        if (clr_req_i && enb_i) begin
          state_d = RF_CLEAR;
          idx_d   = AW'(1);
        end
      end
      RF_CLEAR: begin
        if (enb_i) begin
          idx_d = idx_q + AW'(1);
          if (idx_q == LastIdx) begin
            state_d = RF_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = RF_IDLE;
    endcase
  end

  always_comb begin
    busy_o    = (state_q == RF_CLEAR);
    clr_we_o  = (state_q == RF_CLEAR) && enb_i;
    clr_idx_o = idx_q;
    done_o    = done_q;
    state_o   = state_q;
  end

endmodule

// File: rtl/regfile_mp_scb.sv
// Multi-read, dual-write integer register file with write-to-read bypass,
// per-register pending scoreboard and a sequential bulk-clear engine.
module regfile_mp_scb
  import rf_pkg::*;
#(
  parameter  int unsigned XLEN = RF_XLEN_DEF,
  parameter  int unsigned NREG = RF_NREG_DEF,
  parameter  int unsigned NRD  = 2,
  localparam int unsigned AW   = rf_aw(NREG)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                enb_i,
  input  logic [NRD*AW-1:0]   rs_addr_i,
  output logic [NRD*XLEN-1:0] rs_data_o,
  output logic [NRD-1:0]      rs_rdy_o,
  input  logic                wr0_en_i,
  input  logic [AW-1:0]       wr0_addr_i,
  input  logic [XLEN-1:0]     wr0_data_i,
  input  logic                wr1_en_i,
  input  logic [AW-1:0]       wr1_addr_i,
  input  logic [XLEN-1:0]     wr1_data_i,
  input  logic                pend_set_i,
  input  logic [AW-1:0]       pend_addr_i,
  input  logic                clr_req_i,
  output logic                busy_o,
  output logic                done_o
);

  logic [XLEN-1:0] regs_q [NREG];
  logic [XLEN-1:0] regs_d [NREG];
  logic [NREG-1:0] pend_q, pend_d;

  logic            clr_we;
  logic [AW-1:0]   clr_idx;
  rf_state_e       fsm_state;
  logic            wr_ok;
  logic            wr0_hit, wr1_hit, ps_hit;

  rf_clear_fsm #(
    .NREG (NREG),
    .AW   (AW)
  ) u_clear_fsm (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .enb_i     (enb_i),
    .clr_req_i (clr_req_i),
    .busy_o    (busy_o),
    .done_o    (done_o),
    .clr_we_o  (clr_we),
    .clr_idx_o (clr_idx),
    .state_o   (fsm_state)
  );

  // Writes and pend_set only take effect (and are only bypassed) when idle.
  always_comb begin
    wr_ok   = enb_i && (fsm_state == RF_IDLE);
    wr0_hit = wr_ok && wr0_en_i && (wr0_addr_i != '0);
    wr1_hit = wr_ok && wr1_en_i && (wr1_addr_i != '0);
    ps_hit  = wr_ok && pend_set_i && (pend_addr_i != '0);
  end

  // Order matters: wr1 overrides wr0, and pend_set overrides a write's clear.
  always_comb begin
    regs_d = regs_q;
    pend_d = pend_q;
    if (clr_we) begin
      regs_d[clr_idx] = '0;
      pend_d[clr_idx] = 1'b0;
    end
    if (wr0_hit) begin
      regs_d[wr0_addr_i] = wr0_data_i;
      pend_d[wr0_addr_i] = 1'b0;
    end
    if (wr1_hit) begin
      regs_d[wr1_addr_i] = wr1_data_i;
      pend_d[wr1_addr_i] = 1'b0;
    end
    if (ps_hit) begin
      pend_d[pend_addr_i] = 1'b1;
    end
    regs_d[0] = '0;
    pend_d[0] = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
      pend_q <= '0;
    end else begin
      regs_q <= regs_d;
      pend_q <= pend_d;
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0]   rd_addr;
    logic [XLEN-1:0] rd_data;
    logic            rd_rdy;

    assign rd_addr = rs_addr_i[k*AW +: AW];

    always_comb begin
      rd_data = regs_q[rd_addr];
      rd_rdy  = ~pend_q[rd_addr];
      if (rd_addr == '0) begin
        rd_data = '0;
        rd_rdy  = 1'b1;
      end else if (wr1_hit && (wr1_addr_i == rd_addr)) begin
        rd_data = wr1_data_i;
        rd_rdy  = 1'b1;
      end else if (wr0_hit && (wr0_addr_i == rd_addr)) begin
        rd_data = wr0_data_i;
        rd_rdy  = 1'b1;
      end
    end

    assign rs_data_o[k*XLEN +: XLEN] = rd_data;
    assign rs_rdy_o[k]               = rd_rdy;
  end

endmodule

// File: tb/tb_regfile_mp_scb.sv
// Self-checking bench for regfile_mp_scb: directed vector table, randomized
// traffic against an array-based reference model, and bulk-clear sequences.
module tb_regfile_mp_scb;
  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int NRD  = 2;
  localparam int AW   = 5;

  // ---------------- clock / reset ----------------
  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk_i = ~clk_i;

  logic                enb_i;
  logic [AW-1:0]       rs_a0, rs_a1;
  logic [NRD*AW-1:0]   rs_addr_i;
  logic [NRD*XLEN-1:0] rs_data_o;
  logic [NRD-1:0]      rs_rdy_o;
  logic                wr0_en_i, wr1_en_i, pend_set_i, clr_req_i;
  logic [AW-1:0]       wr0_addr_i, wr1_addr_i, pend_addr_i;
  logic [XLEN-1:0]     wr0_data_i, wr1_data_i;
  logic                busy_o, done_o;

  assign rs_addr_i = {rs_a1, rs_a0};

  regfile_mp_scb #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .enb_i       (enb_i),
    .rs_addr_i   (rs_addr_i),
    .rs_data_o   (rs_data_o),
    .rs_rdy_o    (rs_rdy_o),
    .wr0_en_i    (wr0_en_i),
    .wr0_addr_i  (wr0_addr_i),
    .wr0_data_i  (wr0_data_i),
    .wr1_en_i    (wr1_en_i),
    .wr1_addr_i  (wr1_addr_i),
    .wr1_data_i  (wr1_data_i),
    .pend_set_i  (pend_set_i),
    .pend_addr_i (pend_addr_i),
    .clr_req_i   (clr_req_i),
    .busy_o      (busy_o),
    .done_o      (done_o)
  );

  // ---------------- scoreboard / counters ----------------
  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [XLEN-1:0] m_reg [NREG];
  bit              m_pend [NREG];

  task automatic m_zero();
    for (int i = 0; i < NREG; i++) begin
      m_reg[i]  = '0;
      m_pend[i] = 1'b0;
    end
  endtask

  function automatic void m_read(input logic [AW-1:0] a, output logic [XLEN-1:0] d,
                                 output bit r);
    d = m_reg[a];
    r = !m_pend[a];
    if (a == 0) begin
      d = '0;
      r = 1'b1;
    end else if (enb_i && wr1_en_i && wr1_addr_i == a) begin
      d = wr1_data_i;
      r = 1'b1;
    end else if (enb_i && wr0_en_i && wr0_addr_i == a) begin
      d = wr0_data_i;
      r = 1'b1;
    end
  endfunction

  // Architectural effect of one idle-state clock edge.
  task automatic m_commit();
    if (enb_i) begin
      if (wr0_en_i && wr0_addr_i != 0) begin
        m_reg[wr0_addr_i]  = wr0_data_i;
        m_pend[wr0_addr_i] = 1'b0;
      end
      if (wr1_en_i && wr1_addr_i != 0) begin
        m_reg[wr1_addr_i]  = wr1_data_i;
        m_pend[wr1_addr_i] = 1'b0;
      end
      if (pend_set_i && pend_addr_i != 0) m_pend[pend_addr_i] = 1'b1;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    enb_i = 1'b1;
    wr0_en_i = 1'b0; wr0_addr_i = '0; wr0_data_i = '0;
    wr1_en_i = 1'b0; wr1_addr_i = '0; wr1_data_i = '0;
    pend_set_i = 1'b0; pend_addr_i = '0;
    clr_req_i = 1'b0;
    rs_a0 = '0; rs_a1 = '0;
  endtask

  task automatic step_commit();
    @(posedge clk_i);
    m_commit();
    #1;
  endtask

  task automatic load_index();
    for (int a = 1; a < NREG; a++) begin
      drive_idle();
      wr0_en_i = 1'b1; wr0_addr_i = AW'(a); wr0_data_i = XLEN'(a);
      step_commit();
    end
    drive_idle();
  endtask

  task automatic pulse_clr();
    clr_req_i = 1'b1;
    @(posedge clk_i);
    #1;
    clr_req_i = 1'b0;
  endtask

  task automatic read_all_zero(input string tag);
    for (int a = 0; a < NREG; a++) begin
      rs_a0 = AW'(a);
      rs_a1 = AW'(NREG - 1 - a);
      #1;
      chk({tag, "_d0"}, rs_data_o[XLEN-1:0], 0);
      chk({tag, "_d1"}, rs_data_o[2*XLEN-1:XLEN], 0);
      chk({tag, "_r"}, rs_rdy_o, 2'b11);
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit enb; bit w0e; logic [AW-1:0] w0a; logic [XLEN-1:0] w0d;
    bit w1e; logic [AW-1:0] w1a; logic [XLEN-1:0] w1d;
    bit ps; logic [AW-1:0] psa; logic [AW-1:0] r0; logic [AW-1:0] r1;
    logic [XLEN-1:0] ed0; bit er0; logic [XLEN-1:0] ed1; bit er1;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(bit enb, bit w0e, int w0a, logic [XLEN-1:0] w0d,
                              bit w1e, int w1a, logic [XLEN-1:0] w1d, bit ps, int psa,
                              int r0, int r1, logic [XLEN-1:0] ed0, bit er0,
                              logic [XLEN-1:0] ed1, bit er1);
    vec_t v;
    v.enb = enb; v.w0e = w0e; v.w0a = AW'(w0a); v.w0d = w0d;
    v.w1e = w1e; v.w1a = AW'(w1a); v.w1d = w1d; v.ps = ps; v.psa = AW'(psa);
    v.r0 = AW'(r0); v.r1 = AW'(r1); v.ed0 = ed0; v.er0 = er0; v.ed1 = ed1; v.er1 = er1;
    return v;
  endfunction

  int busy_n, done_n, done_busy;
  logic [XLEN-1:0] md;
  bit              mr;

  initial begin
    vt.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 5, 0, 0, 1, 0, 1));
    vt.push_back(mk(1, 1, 3, 32'h1234_5678, 1, 3, 32'hDEAD_BEEF, 0, 0, 3, 3,
                    32'hDEAD_BEEF, 1, 32'hDEAD_BEEF, 1));
    vt.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 3, 0, 32'hDEAD_BEEF, 1, 0, 1));
    vt.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 7, 7, 3, 0, 1, 32'hDEAD_BEEF, 1));
    vt.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 7, 7, 0, 0, 0, 0));
    vt.push_back(mk(1, 1, 7, 32'hA5, 0, 0, 0, 0, 0, 7, 3, 32'hA5, 1, 32'hDEAD_BEEF, 1));
    vt.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 7, 3, 32'hA5, 1, 32'hDEAD_BEEF, 1));
    vt.push_back(mk(1, 0, 0, 0, 1, 9, 32'h55, 1, 9, 9, 9, 32'h55, 1, 32'h55, 1));
    vt.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 9, 7, 32'h55, 0, 32'hA5, 1));
    vt.push_back(mk(0, 1, 5, 32'h77, 1, 6, 32'h88, 1, 10, 5, 6, 0, 1, 0, 1));
    vt.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 5, 10, 0, 1, 0, 1));
    vt.push_back(mk(1, 1, 0, 32'hFF, 1, 12, 32'hC3, 1, 0, 0, 12, 0, 1, 32'hC3, 1));
    vt.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 12, 0, 1, 32'hC3, 1));
    vt.push_back(mk(1, 1, 9, 32'h11, 1, 8, 32'h22, 0, 0, 9, 8, 32'h11, 1, 32'h22, 1));
    vt.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 9, 8, 32'h11, 1, 32'h22, 1));

    // Reset
    drive_idle();
    m_zero();
    rst_ni = 1'b0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    @(posedge clk_i);
    #1;

    // Directed table
    foreach (vt[i]) begin
      enb_i = vt[i].enb;
      wr0_en_i = vt[i].w0e; wr0_addr_i = vt[i].w0a; wr0_data_i = vt[i].w0d;
      wr1_en_i = vt[i].w1e; wr1_addr_i = vt[i].w1a; wr1_data_i = vt[i].w1d;
      pend_set_i = vt[i].ps; pend_addr_i = vt[i].psa;
      rs_a0 = vt[i].r0; rs_a1 = vt[i].r1;
      @(negedge clk_i);
      chk($sformatf("vec%0d_d0", i), rs_data_o[XLEN-1:0], vt[i].ed0);
      chk($sformatf("vec%0d_r0", i), rs_rdy_o[0], vt[i].er0);
      chk($sformatf("vec%0d_d1", i), rs_data_o[2*XLEN-1:XLEN], vt[i].ed1);
      chk($sformatf("vec%0d_r1", i), rs_rdy_o[1], vt[i].er1);
      step_commit();
    end

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      int hi;
      hi = ($urandom_range(0, 1) == 0) ? 7 : NREG - 1;
      enb_i       = ($urandom_range(0, 9) != 0);
      wr0_en_i    = $urandom_range(0, 1);
      wr0_addr_i  = AW'($urandom_range(0, hi));
      wr0_data_i  = $urandom;
      wr1_en_i    = $urandom_range(0, 1);
      wr1_addr_i  = AW'($urandom_range(0, hi));
      wr1_data_i  = $urandom;
      pend_set_i  = ($urandom_range(0, 2) == 0);
      pend_addr_i = AW'($urandom_range(0, hi));
      rs_a0       = AW'($urandom_range(0, hi));
      rs_a1       = AW'($urandom_range(0, hi));
      @(negedge clk_i);
      m_read(rs_a0, md, mr);
      chk("rnd_d0", rs_data_o[XLEN-1:0], md);
      chk("rnd_r0", rs_rdy_o[0], mr);
      m_read(rs_a1, md, mr);
      chk("rnd_d1", rs_data_o[2*XLEN-1:XLEN], md);
      chk("rnd_r1", rs_rdy_o[1], mr);
      step_commit();
    end
    drive_idle();

    // Full bulk clear with mid-clear write / bypass / re-request attempts
    load_index();
    pulse_clr();
    busy_n = 0; done_n = 0; done_busy = 0;
    for (int c = 1; c <= 40; c++) begin
      if (c == 10) begin
        wr0_en_i = 1'b1; wr0_addr_i = 4; wr0_data_i = 32'hDEAD;
        wr1_en_i = 1'b1; wr1_addr_i = 20; wr1_data_i = 32'h1234;
        pend_set_i = 1'b1; pend_addr_i = 25;
        clr_req_i = 1'b1; rs_a0 = 20; rs_a1 = 4;
      end
      @(negedge clk_i);
      if (c == 10) begin
        chk("clr_nobypass_d", rs_data_o[XLEN-1:0], 20);
        chk("clr_nobypass_r", rs_rdy_o[0], 1);
        chk("clr_x4_cleared", rs_data_o[2*XLEN-1:XLEN], 0);
      end
      if (busy_o) busy_n++;
      if (done_o) begin
        done_n++;
        if (busy_o) done_busy++;
      end
      @(posedge clk_i);
      #1;
      if (c == 10) drive_idle();
    end
    chk("clr_busy_cycles", busy_n, 31);
    chk("clr_done_pulses", done_n, 1);
    chk("clr_done_not_busy", done_busy, 0);
    m_zero();
    read_all_zero("clr_after");
    rs_a0 = 4;
    #1;
    chk("clr_x4_dropped", rs_data_o[XLEN-1:0], 0);

    // Reset in the middle of a clear, then a fresh full clear
    load_index();
    pulse_clr();
    for (int c = 1; c <= 10; c++) @(negedge clk_i);
    chk("rstmid_busy_before", busy_o, 1);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("rstmid_busy", busy_o, 0);
    chk("rstmid_done", done_o, 0);
    read_all_zero("rstmid");
    m_zero();
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
    drive_idle();
    pulse_clr();
    busy_n = 0; done_n = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk_i);
      if (busy_o) busy_n++;
      if (done_o) done_n++;
    end
    chk("reclr_busy_cycles", busy_n, 31);
    chk("reclr_done_pulses", done_n, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard time limit so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule
